// File: rtl/mips_pkg.sv
// Shared types for the instruction-memory boot loader.
// Boot FSM state encoding and word geometry.
package mips_pkg;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } boot_state_t;

  localparam int INSTR_W        = 32;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/boot_word_assembler.sv
// Packs a strobed byte stream into big-endian 32-bit words.
// Emits a one-cycle word_valid_o pulse after the 4th byte of each word.
module boot_word_assembler
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         byte_i,
  input  logic               strb_i,
  output logic [1:0]         lane_o,
  output logic [INSTR_W-1:0] word_o,
  output logic               word_valid_o
);

  localparam logic [1:0] LAST = 2'(BYTES_PER_WORD - 1);

  logic [1:0]         lane_q;
  logic [23:0]        sh_q;
  logic [INSTR_W-1:0] word_q;
  logic               valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q  <= '0;
      sh_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= strb_i && (lane_q == LAST);
      if (strb_i) begin
        lane_q <= lane_q + 2'd1;
        sh_q   <= {sh_q[15:0], byte_i};
        if (lane_q == LAST)
          word_q <= {sh_q, byte_i};
      end
    end
  end

  assign lane_o       = lane_q;
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a length-prefixed image into instruction memory, then releases the core.
// Optional trailing XOR checksum byte: IMEM_BOOT_LOADER_CHECKSUM_EN.
module imem_boot_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_reset_n,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [16:0]   CAP  = 17'(1) << ADDR_W;
  localparam logic [ADDR_W:0] ONE = 1;
  localparam logic [1:0]    LAST = 2'(BYTES_PER_WORD - 1);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  localparam boot_state_t   TAIL = CSUM;
`else
  localparam boot_state_t   TAIL = DONE;
`endif

  boot_state_t       state_q, state_d;
  logic              in_ready_q, busy_q, done_q, err_q, crn_q;
  logic [7:0]        len_hi_q;
  logic [ADDR_W:0]   n_q, widx_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       len;
  logic [1:0]        lane;
  logic              xfer, byte3;

  assign xfer  = in_valid & in_ready_q;
  assign len   = {len_hi_q, in_data};
  assign byte3 = xfer && (state_q == DATA) && (lane == LAST);

  boot_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (reset),
    .byte_i       (in_data),
    .strb_i       (xfer && (state_q == DATA)),
    .lane_o       (lane),
    .word_o       (imem_wdata),
    .word_valid_o (imem_we)
  );

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;

  always_ff @(posedge clk) begin
    if (!reset)
      csum_q <= '0;
    else if (xfer && state_q != CSUM)
      csum_q <= csum_q ^ in_data;
  end
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LEN_HI: if (xfer) state_d = LEN_LO;
      LEN_LO: if (xfer) begin
        if (len == '0)
          state_d = TAIL;
        else if ({1'b0, len} > CAP)
          state_d = ERR;
        else
          state_d = DATA;
      end
      DATA: if (byte3 && (widx_q + ONE) == n_q)
        state_d = TAIL;
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
      CSUM: if (xfer)
        state_d = (in_data == csum_q) ? DONE : ERR;
`else
      CSUM: state_d = ERR;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= LEN_HI;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      crn_q      <= 1'b0;
      len_hi_q   <= '0;
      n_q        <= '0;
      widx_q     <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= state_d inside {LEN_HI, LEN_LO, DATA, CSUM};
      busy_q     <= state_d inside {LEN_LO, DATA, CSUM};
      done_q     <= state_d == DONE;
      err_q      <= state_d == ERR;
      // Core release trails DONE entry by one cycle.
      crn_q      <= state_q == DONE;
      if (xfer && state_q == LEN_HI)
        len_hi_q <= in_data;
      if (xfer && state_q == LEN_LO)
        n_q <= len[ADDR_W:0];
      if (byte3) begin
        addr_q <= widx_q[ADDR_W-1:0];
        widx_q <= widx_q + ONE;
      end
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_addr    = addr_q;
  assign cpu_reset_n  = crn_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = err_q;
  assign words_loaded = widx_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader.
// Build with +define+IMEM_BOOT_LOADER_CHECKSUM_EN to cover the checksum tail.
module tb_imem_boot_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready, imem_we, cpu_reset_n, busy, done, error;
  logic [5:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [6:0] words_loaded;

  int n_tests = 0;
  int n_fail  = 0;

  logic [5:0]  wa[$];
  logic [31:0] wd[$];

  imem_boot_loader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_reset_n  (cpu_reset_n),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (reset && imem_we) begin
      wa.push_back(imem_addr);
      wd.push_back(imem_wdata);
    end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    wa.delete();
    wd.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_img2(input int gap);
    logic [7:0] img[10];
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
            8'h00, 8'h00, 8'h00, 8'h00};
    foreach (img[i]) send(img[i], gap);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    send(8'h2F, gap);
`endif
  endtask

  task automatic check_img2(input string t);
    chk({t, "_nwr"}, wa.size(), 2);
    if (wa.size() == 2) begin
      chk({t, "_a0"}, wa[0], 0);
      chk({t, "_d0"}, wd[0], 32'h2008_0005);
      chk({t, "_a1"}, wa[1], 1);
      chk({t, "_d1"}, wd[1], 32'h0000_0000);
    end
    chk({t, "_wl"}, words_loaded, 2);
    chk({t, "_done"}, done, 1);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_rdy"}, in_ready, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    // 1: reset values
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", in_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_crn", cpu_reset_n, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_wl", words_loaded, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rel_rdy", in_ready, 1);
    chk("rel_crn", cpu_reset_n, 0);

    // 2: back-to-back image
    send(8'h00, 0);
    chk("t2_busy_early", busy, 1);
    send(8'h02, 0);
    send(8'h20, 0); send(8'h08, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    send(8'h2F, 0);
`endif
    chk("t2_crn_lag", cpu_reset_n, 0);
    @(posedge clk);
    #1;
    chk("t2_crn", cpu_reset_n, 1);
    check_img2("t2");

    // 3: in_valid toggling
    do_reset();
    send_img2(1);
    @(posedge clk);
    #1;
    chk("t3_crn", cpu_reset_n, 1);
    check_img2("t3");

    // 4: oversize length
    do_reset();
    send(8'h00, 0);
    send(8'h41, 0);
    chk("t4_err", error, 1);
    chk("t4_rdy", in_ready, 0);
    chk("t4_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAB;
    repeat (6) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("t4_nwr", wa.size(), 0);
    chk("t4_crn", cpu_reset_n, 0);
    chk("t4_err_sticky", error, 1);
    chk("t4_done", done, 0);

    // boundary: N == capacity is accepted
    do_reset();
    send(8'h00, 0);
    send(8'h40, 0);
    chk("cap_err", error, 0);
    chk("cap_busy", busy, 1);
    chk("cap_rdy", in_ready, 1);

    // 5: reset mid-load then a 1-word image
    do_reset();
    send(8'h00, 0); send(8'h03, 0);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    send(8'h55, 0);
    chk("t5_wl_pre", words_loaded, 1);
    do_reset();
    send(8'h00, 0); send(8'h01, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    send(8'h01, 0);
`endif
    @(posedge clk);
    #1;
    chk("t5_nwr", wa.size(), 1);
    if (wa.size() == 1) begin
      chk("t5_a0", wa[0], 0);
      chk("t5_d0", wd[0], 32'hAABB_CCDD);
    end
    chk("t5_done", done, 1);
    chk("t5_wl", words_loaded, 1);
    chk("t5_crn", cpu_reset_n, 1);

    // empty image
    do_reset();
    send(8'h00, 0); send(8'h00, 0);
`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    chk("empty_done", done, 1);
    chk("empty_wl", words_loaded, 0);
    chk("empty_nwr", wa.size(), 0);

`ifdef IMEM_BOOT_LOADER_CHECKSUM_EN
    // 6: checksum good then bad
    do_reset();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    chk("t6_rdy_csum", in_ready, 1);
    send(8'h09, 0);
    chk("t6_done", done, 1);
    chk("t6_d0", (wd.size() == 1) ? wd[0] : 32'hx, 32'h1234_5678);
    do_reset();
    send(8'h00, 0); send(8'h01, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    send(8'h08, 0);
    @(posedge clk);
    #1;
    chk("t6_err", error, 1);
    chk("t6_bad_done", done, 0);
    chk("t6_crn", cpu_reset_n, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
